// File: rtl/hc_sr04_responder.sv
// HC-SR04 ultrasonic sensor model: accepts a trigger pulse, waits a burst
// delay, then returns an echo pulse whose width encodes a target distance.
// Ports:
//   clk, rst         sensor clock, asynchronous active-high reset
//   i_trig           trigger from controller (asynchronous, synchronized here)
//   i_distance_cm    emulated distance, sampled when a trigger is accepted
//   i_no_target      1 = no echo return, timeout-width echo
//   o_echo           echo pulse to controller
//   o_busy           high in DELAY, ECHO and HOLDOFF
//   o_err_short      one-cycle pulse on a too-short trigger
//   o_trig_count     accepted trigger count, wraps at 255
module hc_sr04_responder #(
   parameter int unsigned CLK_FREQ_HZ        = 64_000_000,
   parameter int unsigned CYCLES_PER_CM      = 3712,
   parameter int unsigned TRIG_MIN_CYCLES    = 640,
   parameter int unsigned BURST_DELAY_CYCLES = 12800,
   parameter int unsigned TIMEOUT_CYCLES     = 2_432_000,
   parameter int unsigned HOLDOFF_CYCLES     = 640_000,
   parameter int unsigned MIN_CM             = 2,
   parameter int unsigned MAX_CM             = 400
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_trig,
   input  logic [8:0] i_distance_cm,
   input  logic       i_no_target,
   output logic       o_echo,
   output logic       o_busy,
   output logic       o_err_short,
   output logic [7:0] o_trig_count
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TRIG,
      ST_DELAY,
      ST_ECHO,
      ST_HOLDOFF
   } state_t;

   localparam logic [8:0]  MIN_D = 9'(MIN_CM);
   localparam logic [8:0]  MAX_D = 9'(MAX_CM);
   localparam logic [31:0] T_MIN = 32'(TRIG_MIN_CYCLES);
   localparam logic [31:0] T_BST = 32'(BURST_DELAY_CYCLES);
   localparam logic [31:0] T_TMO = 32'(TIMEOUT_CYCLES);
   localparam logic [31:0] T_HLD = 32'(HOLDOFF_CYCLES);
   localparam logic [31:0] K_CM  = 32'(CYCLES_PER_CM);

   state_t      state, state_nx;
   logic [31:0] cnt, cnt_nx;
   logic [31:0] width, width_nx;
   logic [31:0] width_calc;
   logic [8:0]  dist_sel;
   logic [7:0]  tcount_nx;
   logic        echo_nx;
   logic        err_nx;
   logic        trig_m, trig_s, trig_d;
   logic        trig_rise;

   // Synchronizer and edge history reset to 1: a trigger already high
   // at reset release must fall and rise again before it is seen.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trig_m <= 1'b1;
         trig_s <= 1'b1;
         trig_d <= 1'b1;
      end else begin
         trig_m <= i_trig;
         trig_s <= trig_m;
         trig_d <= trig_s;
      end
   end

   assign trig_rise = trig_s & ~trig_d;

   assign dist_sel = (i_distance_cm < MIN_D) ? MIN_D : i_distance_cm;

   always_comb begin
      width_calc = {23'd0, dist_sel} * K_CM;
      if (i_no_target || (i_distance_cm > MAX_D))
         width_calc = T_TMO;
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         cnt          <= '0;
         width        <= '0;
         o_echo       <= 1'b0;
         o_err_short  <= 1'b0;
         o_trig_count <= '0;
      end else begin
         state        <= state_nx;
         cnt          <= cnt_nx;
         width        <= width_nx;
         o_echo       <= echo_nx;
         o_err_short  <= err_nx;
         o_trig_count <= tcount_nx;
      end
   end

   // Next-state logic; counters restart on every state entry
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      width_nx  = width;
      echo_nx   = 1'b0;
      err_nx    = 1'b0;
      tcount_nx = o_trig_count;
      unique case (state)
         ST_IDLE: begin
            if (trig_rise) begin
               state_nx = ST_TRIG;
               cnt_nx   = 32'd1;
            end
         end
         ST_TRIG: begin
            if (trig_s) begin
               if (cnt < T_MIN)
                  cnt_nx = cnt + 32'd1;
            end else if (cnt >= T_MIN) begin
               state_nx  = ST_DELAY;
               cnt_nx    = '0;
               width_nx  = width_calc;
               tcount_nx = o_trig_count + 8'd1;
            end else begin
               state_nx = ST_IDLE;
               cnt_nx   = '0;
               err_nx   = 1'b1;
            end
         end
         ST_DELAY: begin
            if (cnt >= T_BST) begin
               state_nx = ST_ECHO;
               cnt_nx   = 32'd1;
               echo_nx  = 1'b1;
            end else begin
               cnt_nx = cnt + 32'd1;
            end
         end
         ST_ECHO: begin
            if (cnt >= width) begin
               state_nx = ST_HOLDOFF;
               cnt_nx   = 32'd1;
            end else begin
               cnt_nx  = cnt + 32'd1;
               echo_nx = 1'b1;
            end
         end
         ST_HOLDOFF: begin
            if (cnt >= T_HLD) begin
               state_nx = ST_IDLE;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + 32'd1;
            end
         end
         default: begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   // Output logic
   always_comb begin
      o_busy = (state == ST_DELAY) || (state == ST_ECHO) ||
               (state == ST_HOLDOFF);
   end

endmodule

// File: tb/tb_hc_sr04_responder.sv
// Directed testbench for hc_sr04_responder with shortened timing
// parameters; each scenario task checks its own results inline.
module tb_hc_sr04_responder;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_trig;
   logic [8:0] i_distance_cm;
   logic       i_no_target;
   logic       o_echo;
   logic       o_busy;
   logic       o_err_short;
   logic [7:0] o_trig_count;

   int total = 0;
   int bad   = 0;
   int rises = 0;

   hc_sr04_responder #(
      .CYCLES_PER_CM(4),
      .TRIG_MIN_CYCLES(10),
      .BURST_DELAY_CYCLES(20),
      .TIMEOUT_CYCLES(2000),
      .HOLDOFF_CYCLES(50)
   ) dut (
      .clk(clk),
      .rst(rst),
      .i_trig(i_trig),
      .i_distance_cm(i_distance_cm),
      .i_no_target(i_no_target),
      .o_echo(o_echo),
      .o_busy(o_busy),
      .o_err_short(o_err_short),
      .o_trig_count(o_trig_count)
   );

   always #5 clk = ~clk;

   always @(posedge o_echo) rises++;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse(input int n);
      i_trig = 1'b1;
      repeat (n) step();
      i_trig = 1'b0;
   endtask

   // Follows one measurement: busy rise -> echo rise -> echo fall -> idle
   task automatic measure(input bit chg, input logic [8:0] nd,
                          output int lat, output int w, output int h,
                          output bit to);
      int k;
      to = 1'b0; lat = 0; w = 0; h = 0; k = 0;
      while (!o_busy && k < 100) begin step(); k++; end
      if (!o_busy) begin to = 1'b1; return; end
      if (chg) i_distance_cm = nd;
      while (!o_echo && lat < 1000) begin step(); lat++; end
      if (!o_echo) begin to = 1'b1; return; end
      while (o_echo && w < 10000) begin step(); w++; end
      while (o_busy && h < 1000) begin step(); h++; end
      if (o_echo || o_busy) to = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; i_trig = 1'b0; i_distance_cm = '0; i_no_target = 1'b0;
      repeat (3) step();
      total++;
      if ({o_echo, o_busy, o_err_short, o_trig_count} !== 11'd0) begin
         bad++;
         $display("FAIL reset: got echo=%b busy=%b err=%b cnt=%0d want 0",
                  o_echo, o_busy, o_err_short, o_trig_count);
      end
      rst = 1'b0;
      repeat (5) step();
   endtask

   task automatic test_basic();
      int lat, w, h; bit to;
      i_distance_cm = 9'd100;
      pulse(12);
      measure(1'b0, '0, lat, w, h, to);
      total++;
      if (to !== 1'b0 || lat !== 21) begin
         bad++; $display("FAIL basic_lat: got %0d to=%b want 21", lat, to);
      end
      total++;
      if (w !== 400) begin
         bad++; $display("FAIL basic_width: got %0d want 400", w);
      end
      total++;
      if (h !== 50) begin
         bad++; $display("FAIL basic_holdoff: got %0d want 50", h);
      end
      total++;
      if (o_trig_count !== 8'd1) begin
         bad++; $display("FAIL basic_count: got %0d want 1", o_trig_count);
      end
   endtask

   task automatic test_short();
      int errs, busy_seen, r0, lat, w, h; bit to;
      logic [7:0] c0;
      c0 = o_trig_count; r0 = rises; errs = 0; busy_seen = 0;
      pulse(5);
      repeat (30) begin
         if (o_err_short) errs++;
         if (o_busy) busy_seen++;
         step();
      end
      total++;
      if (errs !== 1) begin
         bad++; $display("FAIL short_err: got %0d pulses want 1", errs);
      end
      total++;
      if (busy_seen !== 0 || rises !== r0) begin
         bad++; $display("FAIL short_idle: busy=%0d echoes=%0d want 0 0",
                         busy_seen, rises - r0);
      end
      total++;
      if (o_trig_count !== c0) begin
         bad++; $display("FAIL short_count: got %0d want %0d", o_trig_count, c0);
      end
      errs = 0;
      pulse(9);
      repeat (30) begin
         if (o_err_short) errs++;
         step();
      end
      total++;
      if (errs !== 1 || o_trig_count !== c0) begin
         bad++; $display("FAIL short_9: got err=%0d cnt=%0d want 1 %0d",
                         errs, o_trig_count, c0);
      end
      i_distance_cm = 9'd5;
      pulse(10);
      measure(1'b0, '0, lat, w, h, to);
      total++;
      if (to !== 1'b0 || w !== 20 || o_trig_count !== c0 + 8'd1) begin
         bad++; $display("FAIL trig_10: got w=%0d cnt=%0d to=%b want 20 %0d 0",
                         w, o_trig_count, to, c0 + 8'd1);
      end
   endtask

   task automatic test_width();
      int lat, w, h; bit to;
      int          td[7] = '{0, 1, 2, 401, 400, 400, 511};
      bit          tn[7] = '{0, 0, 0, 0, 1, 0, 0};
      int          tw[7] = '{8, 8, 8, 2000, 2000, 1600, 2000};
      for (int i = 0; i < 7; i++) begin
         i_distance_cm = 9'(td[i]);
         i_no_target = tn[i];
         pulse(12);
         measure(1'b0, '0, lat, w, h, to);
         total++;
         if (to !== 1'b0 || w !== tw[i]) begin
            bad++;
            $display("FAIL width d=%0d nt=%0d: got %0d to=%b want %0d",
                     td[i], tn[i], w, to, tw[i]);
         end
      end
      i_no_target = 1'b0;
   endtask

   task automatic test_ignore();
      int k, r0, lat, w, h; bit to;
      logic [7:0] c0;
      c0 = o_trig_count; r0 = rises;
      i_distance_cm = 9'd100;
      pulse(12);
      k = 0;
      while (!o_echo && k < 200) begin step(); k++; end
      repeat (50) step();
      pulse(12);
      k = 0;
      while (o_echo && k < 1000) begin step(); k++; end
      repeat (10) step();
      pulse(12);
      k = 0;
      while (o_busy && k < 200) begin step(); k++; end
      total++;
      if (o_busy !== 1'b0 || rises - r0 !== 1) begin
         bad++; $display("FAIL ignore_echoes: got %0d busy=%b want 1 0",
                         rises - r0, o_busy);
      end
      total++;
      if (o_trig_count !== c0 + 8'd1) begin
         bad++; $display("FAIL ignore_count: got %0d want %0d",
                         o_trig_count, c0 + 8'd1);
      end
      repeat (5) step();
      pulse(12);
      measure(1'b0, '0, lat, w, h, to);
      total++;
      if (to !== 1'b0 || w !== 400 || o_trig_count !== c0 + 8'd2) begin
         bad++; $display("FAIL ignore_third: got w=%0d cnt=%0d to=%b want 400 %0d 0",
                         w, o_trig_count, to, c0 + 8'd2);
      end
   endtask

   task automatic test_reset_mid();
      int k, r0, busy_seen, lat, w, h; bit to;
      i_distance_cm = 9'd100;
      pulse(12);
      k = 0;
      while (!o_echo && k < 200) begin step(); k++; end
      repeat (200) step();
      total++;
      if (o_echo !== 1'b1) begin
         bad++; $display("FAIL mid_pre: echo got %b want 1", o_echo);
      end
      #3;
      rst = 1'b1;
      i_trig = 1'b1;
      #1;
      total++;
      if ({o_echo, o_busy, o_err_short, o_trig_count} !== 11'd0) begin
         bad++;
         $display("FAIL mid_async: got echo=%b busy=%b err=%b cnt=%0d want 0",
                  o_echo, o_busy, o_err_short, o_trig_count);
      end
      step();
      step();
      rst = 1'b0;
      r0 = rises; busy_seen = 0;
      repeat (60) begin
         if (o_busy) busy_seen++;
         step();
      end
      total++;
      if (busy_seen !== 0 || rises !== r0 || o_trig_count !== 8'd0) begin
         bad++; $display("FAIL mid_held: busy=%0d echoes=%0d cnt=%0d want 0 0 0",
                         busy_seen, rises - r0, o_trig_count);
      end
      i_trig = 1'b0;
      repeat (5) step();
      pulse(12);
      measure(1'b0, '0, lat, w, h, to);
      total++;
      if (to !== 1'b0 || w !== 400 || o_trig_count !== 8'd1) begin
         bad++; $display("FAIL mid_repulse: got w=%0d cnt=%0d to=%b want 400 1 0",
                         w, o_trig_count, to);
      end
   endtask

   task automatic test_delay_change();
      int lat, w, h; bit to;
      i_distance_cm = 9'd10;
      pulse(12);
      measure(1'b1, 9'd200, lat, w, h, to);
      total++;
      if (to !== 1'b0 || w !== 40) begin
         bad++; $display("FAIL delay_change: got %0d to=%b want 40", w, to);
      end
   endtask

   task automatic test_back_to_back();
      int lat, w, h, werr; bit to;
      logic [7:0] c255;
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (5) step();
      i_distance_cm = 9'd0;
      werr = 0; c255 = '0;
      for (int i = 0; i < 256; i++) begin
         pulse(12);
         measure(1'b0, '0, lat, w, h, to);
         if (to || w != 8) werr++;
         if (i == 254) c255 = o_trig_count;
      end
      total++;
      if (c255 !== 8'd255) begin
         bad++; $display("FAIL b2b_255: got %0d want 255", c255);
      end
      total++;
      if (o_trig_count !== 8'd0) begin
         bad++; $display("FAIL b2b_wrap: got %0d want 0", o_trig_count);
      end
      total++;
      if (werr !== 0) begin
         bad++; $display("FAIL b2b_width: got %0d bad echoes want 0", werr);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_short();
      test_width();
      test_ignore();
      test_reset_mid();
      test_delay_change();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
